// File: rtl/adpcm_nibble_packer.sv
// ADPCM nibble packer: gathers four 4-bit ADPCM codes into a 16-bit word
// (first code in [15:12]) and queues finished words in a small circular FIFO.
// flush emits a partial word with its unfilled nibbles zeroed. Overflow is
// sticky until reset.
// Optional build macro ADPCM_PACK_PARITY_EN: adds out_parity, the XOR of
// out_data. The parity bit is stored in the FIFO beside each word.
module adpcm_nibble_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          block_enable,
  input  logic                          in_valid,
  input  logic [3:0]                    in_code,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow
`ifdef ADPCM_PACK_PARITY_EN
  ,
  output logic                          out_parity
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef ADPCM_PACK_PARITY_EN
  localparam int EW = 17;
`else
  localparam int EW = 16;
`endif

  // ---------------- packer ----------------
  logic [1:0]  idx, idx_nxt;
  logic [15:0] part, part_nxt;
  logic [15:0] word_placed;
  logic        accept;
  logic        push;

  // Place the incoming nibble, then decide whether this cycle emits a word.
  // A flush that coincides with the fourth nibble still yields one word.
  always_comb begin
    accept      = block_enable & in_valid;
    word_placed = part;
    if (accept) begin
      case (idx)
        2'd0:    word_placed[15:12] = in_code;
        2'd1:    word_placed[11:8]  = in_code;
        2'd2:    word_placed[7:4]   = in_code;
        default: word_placed[3:0]   = in_code;
      endcase
    end
    push = block_enable &
           ((accept & (idx == 2'd3)) | (flush & ((idx != 2'd0) | accept)));
    if (!block_enable || push) begin
      idx_nxt  = 2'd0;
      part_nxt = 16'h0000;
    end else begin
      idx_nxt  = idx + {1'b0, accept};
      part_nxt = word_placed;
    end
  end

  // Packer state register; disabling the block discards the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= 2'd0;
      part <= 16'h0000;
    end else begin
      idx  <= idx_nxt;
      part <= part_nxt;
    end
  end

  // ---------------- FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Build the stored entry and the push/pop qualifiers. A push into a full
  // FIFO is accepted only when a pop frees a slot in the same cycle.
  always_comb begin
`ifdef ADPCM_PACK_PARITY_EN
    wr_entry = {^word_placed, word_placed};
`else
    wr_entry = word_placed;
`endif
    full  = (count == CW'(FIFO_DEPTH));
    pop   = out_valid & out_ready;
    wr_en = push & (~full | pop);
  end

  // Storage array; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_entry;
  end

  // Pointers, occupancy count and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Head of queue; forced to zero while empty so reset shows 16'h0000.
  always_comb begin
    head       = mem[rptr];
    out_valid  = (count != '0);
    out_data   = out_valid ? head[15:0] : 16'h0000;
    fill_level = count;
`ifdef ADPCM_PACK_PARITY_EN
    out_parity = out_valid ? head[16] : 1'b0;
`endif
  end

endmodule

// File: tb/tb_adpcm_nibble_packer.sv
// Self-checking bench for adpcm_nibble_packer: a directed vector table,
// hand-written corner sequences and a random run, all checked every cycle
// against a queue-based reference model.
module tb_adpcm_nibble_packer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        block_enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_code = 4'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [$clog2(DEPTH):0] fill_level;
  logic        overflow;
`ifdef ADPCM_PACK_PARITY_EN
  logic        out_parity;
`endif

  adpcm_nibble_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .block_enable(block_enable),
    .in_valid(in_valid), .in_code(in_code), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fill_level(fill_level), .overflow(overflow)
`ifdef ADPCM_PACK_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: pending nibbles, queued words, sticky overflow
  logic [3:0]  pend[$];
  logic [15:0] mq[$];
  logic        movf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] ed;
    ed = (mq.size() > 0) ? mq[0] : 16'h0000;
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("fill_level", 32'(fill_level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(movf));
`ifdef ADPCM_PACK_PARITY_EN
    chk("out_parity", 32'(out_parity), 32'((mq.size() > 0) ? ^ed : 1'b0));
`endif
  endtask

  // one clock: drive inputs, advance model at the edge, compare after it
  task automatic cyc(input logic en, input logic v, input logic [3:0] c,
                     input logic fl, input logic rdy);
    bit popped;
    int size_before;
    logic [15:0] w;
    block_enable = en; in_valid = v; in_code = c; flush = fl; out_ready = rdy;
    size_before = mq.size();
    popped = (size_before > 0) && rdy;
    @(posedge clk);
    if (popped) void'(mq.pop_front());
    if (en) begin
      if (v) pend.push_back(c);
      if (pend.size() == 4 || (fl && pend.size() > 0)) begin
        w = 16'h0000;
        for (int i = 0; i < pend.size(); i++) w[15-4*i -: 4] = pend[i];
        pend.delete();
        if (size_before == DEPTH && !popped) movf = 1'b1;
        else mq.push_back(w);
      end
    end else begin
      pend.delete();
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    pend.delete(); mq.delete(); movf = 1'b0;
    block_enable = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [15:0] w, input logic rdy_last);
    for (int n = 0; n < 4; n++)
      cyc(1'b1, 1'b1, w[15-4*n -: 4], 1'b0, (n == 3) ? rdy_last : 1'b0);
  endtask

  typedef struct {
    logic en, v; logic [3:0] c; logic fl, rdy;
    logic ev; logic [15:0] ed; int ef;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int vcnt;
    logic [15:0] seen;
    tbl[0]  = '{1,1,4'hA,0,1, 0,16'h0000,0};
    tbl[1]  = '{1,1,4'hB,0,1, 0,16'h0000,0};
    tbl[2]  = '{1,0,4'h0,1,1, 1,16'hAB00,1};
    tbl[3]  = '{1,0,4'h0,1,1, 0,16'h0000,0};
    tbl[4]  = '{1,0,4'h0,0,1, 0,16'h0000,0};
    tbl[5]  = '{1,1,4'h1,0,1, 0,16'h0000,0};
    tbl[6]  = '{1,1,4'h2,0,1, 0,16'h0000,0};
    tbl[7]  = '{1,1,4'h3,0,1, 0,16'h0000,0};
    tbl[8]  = '{1,1,4'h4,0,1, 1,16'h1234,1};
    tbl[9]  = '{1,0,4'h0,0,1, 0,16'h0000,0};
    tbl[10] = '{1,1,4'h5,0,0, 0,16'h0000,0};
    tbl[11] = '{1,1,4'h6,0,0, 0,16'h0000,0};
    tbl[12] = '{1,1,4'h7,0,0, 0,16'h0000,0};
    tbl[13] = '{1,1,4'h8,1,0, 1,16'h5678,1};
    tbl[14] = '{1,0,4'h0,0,0, 1,16'h5678,1};
    tbl[15] = '{1,0,4'h0,0,1, 0,16'h0000,0};
    tbl[16] = '{1,1,4'hC,1,1, 1,16'hC000,1};
    tbl[17] = '{1,0,4'h0,0,1, 0,16'h0000,0};

    #2;
    do_reset();

    // directed table
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].en, tbl[i].v, tbl[i].c, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_fill", i), 32'(fill_level), 32'(tbl[i].ef));
    end

    // codes 1..4 spaced 64 cycles apart: one word, valid for one cycle
    do_reset();
    vcnt = 0; seen = 16'h0000;
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b1, 4'(k), 1'b0, 1'b1);
      if (out_valid) begin vcnt++; seen = out_data; end
      for (int j = 0; j < 63; j++) begin
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        if (out_valid) begin vcnt++; seen = out_data; end
      end
    end
    chk("spaced_valid_cycles", 32'(vcnt), 32'd1);
    chk("spaced_word", 32'(seen), 32'h1234);
    chk("spaced_fill", 32'(fill_level), 32'd0);

    // nine words into an eight-deep FIFO with no reader
    do_reset();
    for (int w = 1; w <= 9; w++) push_word({4{4'(w)}}, 1'b0);
    chk("ovf_fill", 32'(fill_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int w = 1; w <= 8; w++) begin
      chk($sformatf("ovf_word%0d", w), 32'(out_data), 32'({4{4'(w)}}));
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    end
    chk("ovf_drained", 32'(out_valid), 32'd0);

    // push into a full FIFO coinciding with a pop
    do_reset();
    for (int w = 1; w <= 8; w++) push_word({4{4'(w)}}, 1'b0);
    push_word(16'h9999, 1'b1);
    chk("fullpop_fill", 32'(fill_level), 32'd8);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    for (int w = 2; w <= 9; w++) begin
      chk($sformatf("fullpop_word%0d", w), 32'(out_data), 32'({4{4'(w)}}));
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    end

    // block_enable low discards the partial word
    do_reset();
    cyc(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 4'h7, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'h8, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    chk("disable_fill", 32'(fill_level), 32'd1);
    chk("disable_word", 32'(out_data), 32'h789A);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("disable_empty", 32'(out_valid), 32'd0);

    // reset mid-drain and mid-word, then fresh word lands at idx 0
    push_word(16'h1111, 1'b0);
    push_word(16'h2222, 1'b0);
    cyc(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    do_reset();
    for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("midrst_empty", 32'(out_valid), 32'd0);
    push_word(16'hDEF1, 1'b0);
    chk("midrst_word", 32'(out_data), 32'hDEF1);

`ifdef ADPCM_PACK_PARITY_EN
    do_reset();
    push_word(16'h0001, 1'b0);
    chk("parity_0001", 32'(out_parity), 32'd1);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    push_word(16'h0003, 1'b0);
    chk("parity_0003", 32'(out_parity), 32'd0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
`endif

    // random traffic with phases of slow and stalled readers
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      if (i % 1000 < 300) rdy = ($urandom_range(0, 7) == 0);
      else                rdy = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
